// File: rtl/axi_mm_resp_pkg.sv
// Shared AXI-MM response/burst encodings and the response severity merge.
package axi_mm_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam int BEAT_BYTES = 8;

    // Response codes are ordered by severity, so the merge is a plain max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_mm_burst_addr.sv
// Burst address/beat tracker: holds the current beat address, next address and last-beat flags.
// Latency: 0 (flags and addr_nxt are combinational from registered state); no backpressure of its own.
module axi_mm_burst_addr
    import axi_mm_resp_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_len,
    input  logic [1:0]        ld_burst,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt,
    output logic              last,
    output logic              last_nxt
);

    logic [8:0] beat;
    logic [7:0] len_q;
    logic [1:0] burst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr    <= '0;
            beat    <= '0;
            len_q   <= '0;
            burst_q <= '0;
        end else if (load) begin
            addr    <= ld_addr;
            beat    <= '0;
            len_q   <= ld_len;
            burst_q <= ld_burst;
        end else if (adv) begin
            addr <= addr_nxt;
            // Saturate so an overlong write burst never aliases back onto len.
            if (beat != 9'h1FF)
                beat <= beat + 9'd1;
        end
    end

    always_comb begin
        addr_nxt = (burst_q == BURST_FIXED) ? addr : addr + ADDR_W'(BEAT_BYTES);
    end

    assign last     = (beat == {1'b0, len_q});
    assign last_nxt = ((beat + 9'd1) == {1'b0, len_q});

endmodule

// File: rtl/axi_mm_mem_responder.sv
// AXI-MM memory target on a flop array; independent read and write FSMs, one beat per cycle each.
// Latency: R data one cycle after AR accept, B one cycle after last W; output beats held while not ready.
module axi_mm_mem_responder
    import axi_mm_resp_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64
) (
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic [ID_W-1:0]     user_arid,
    input  logic [2:0]          user_arsize,
    input  logic [7:0]          user_arlen,
    input  logic [1:0]          user_arburst,
    input  logic [ADDR_W-1:0]   user_araddr,
    input  logic                user_arvalid,
    output logic                user_arready,
    input  logic [ID_W-1:0]     user_awid,
    input  logic [2:0]          user_awsize,
    input  logic [7:0]          user_awlen,
    input  logic [1:0]          user_awburst,
    input  logic [ADDR_W-1:0]   user_awaddr,
    input  logic                user_awvalid,
    output logic                user_awready,
    input  logic [ID_W-1:0]     user_wid,
    input  logic [DATA_W-1:0]   user_wdata,
    input  logic [DATA_W/8-1:0] user_wstrb,
    input  logic                user_wlast,
    input  logic                user_wvalid,
    output logic                user_wready,
    output logic [ID_W-1:0]     user_rid,
    output logic [DATA_W-1:0]   user_rdata,
    output logic                user_rlast,
    output logic [1:0]          user_rresp,
    output logic                user_rvalid,
    input  logic                user_rready,
    output logic [ID_W-1:0]     user_bid,
    output logic [1:0]          user_bresp,
    output logic                user_bvalid,
    input  logic                user_bready,
    output logic [31:0]         status
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Any address bit above the array's byte span means the beat is out of range.
    function automatic logic is_oor(input logic [ADDR_W-1:0] a);
        return |a[ADDR_W-1:IDX_W+3];
    endfunction

    // ---------------- write path ----------------
    w_state_e          w_state;
    logic [ID_W-1:0]   w_id;
    logic              w_berr;
    logic [1:0]        w_resp;
    logic [15:0]       wr_cnt;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic [ADDR_W-1:0] w_unused_addr_nxt;
    logic              w_unused_last_nxt;

    logic       aw_hs, w_hs, b_hs, w_oor, mem_we;
    logic [1:0] w_beat_resp;

    assign aw_hs  = user_awvalid && user_awready;
    assign w_hs   = user_wvalid && user_wready;
    assign b_hs   = user_bvalid && user_bready;
    assign w_oor  = is_oor(w_addr);
    assign mem_we = w_hs && !w_oor && !w_berr;
    assign w_beat_resp = resp_max(w_oor ? RESP_DECERR : RESP_OKAY,
                                  (user_wlast != w_last) ? RESP_SLVERR : RESP_OKAY);

    axi_mm_burst_addr #(.ADDR_W(ADDR_W)) u_w_addr (
        .clk      (clk_wr),
        .rst      (rst_wr),
        .load     (aw_hs),
        .ld_addr  (user_awaddr),
        .ld_len   (user_awlen),
        .ld_burst (user_awburst),
        .adv      (w_hs),
        .addr     (w_addr),
        .addr_nxt (w_unused_addr_nxt),
        .last     (w_last),
        .last_nxt (w_unused_last_nxt)
    );

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            w_state      <= W_IDLE;
            user_awready <= 1'b1;
            user_wready  <= 1'b0;
            user_bvalid  <= 1'b0;
            user_bid     <= '0;
            user_bresp   <= '0;
            w_id         <= '0;
            w_berr       <= 1'b0;
            w_resp       <= '0;
            wr_cnt       <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id         <= user_awid;
                    w_berr       <= (user_awburst == BURST_RSVD);
                    w_resp       <= (user_awburst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                    user_awready <= 1'b0;
                    user_wready  <= 1'b1;
                    w_state      <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_resp <= resp_max(w_resp, w_beat_resp);
                    if (user_wlast) begin
                        user_wready <= 1'b0;
                        user_bvalid <= 1'b1;
                        user_bid    <= w_id;
                        user_bresp  <= resp_max(w_resp, w_beat_resp);
                        w_state     <= W_RESP;
                    end
                end
                W_RESP: if (b_hs) begin
                    user_bvalid  <= 1'b0;
                    user_awready <= 1'b1;
                    w_state      <= W_IDLE;
                    if (wr_cnt != 16'hFFFF)
                        wr_cnt <= wr_cnt + 16'd1;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_wr) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++)
                if (user_wstrb[b])
                    mem[w_addr[3 +: IDX_W]][8*b +: 8] <= user_wdata[8*b +: 8];
        end
    end

    // ---------------- read path ----------------
    r_state_e          r_state;
    logic              r_berr;
    logic [15:0]       rd_cnt;
    logic [ADDR_W-1:0] r_addr_nxt;
    logic              r_last_nxt;
    logic [ADDR_W-1:0] r_unused_addr;
    logic              r_unused_last;

    logic              ar_hs, r_hs, r_fetch_berr, r_fetch_oor;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [DATA_W-1:0] r_fetch_dat;
    logic [1:0]        r_fetch_resp;

    assign ar_hs = user_arvalid && user_arready;
    assign r_hs  = user_rvalid && user_rready;

    // The first beat is fetched straight from the AR bus so it can be presented one cycle later.
    assign r_fetch_addr = (r_state == R_IDLE) ? user_araddr : r_addr_nxt;
    assign r_fetch_berr = (r_state == R_IDLE) ? (user_arburst == BURST_RSVD) : r_berr;
    assign r_fetch_oor  = is_oor(r_fetch_addr);
    assign r_fetch_dat  = (r_fetch_oor || r_fetch_berr) ? '0 : mem[r_fetch_addr[3 +: IDX_W]];
    assign r_fetch_resp = resp_max(r_fetch_berr ? RESP_SLVERR : RESP_OKAY,
                                   r_fetch_oor  ? RESP_DECERR : RESP_OKAY);

    axi_mm_burst_addr #(.ADDR_W(ADDR_W)) u_r_addr (
        .clk      (clk_wr),
        .rst      (rst_wr),
        .load     (ar_hs),
        .ld_addr  (user_araddr),
        .ld_len   (user_arlen),
        .ld_burst (user_arburst),
        .adv      (r_hs && !user_rlast),
        .addr     (r_unused_addr),
        .addr_nxt (r_addr_nxt),
        .last     (r_unused_last),
        .last_nxt (r_last_nxt)
    );

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state      <= R_IDLE;
            user_arready <= 1'b1;
            user_rvalid  <= 1'b0;
            user_rdata   <= '0;
            user_rresp   <= '0;
            user_rlast   <= 1'b0;
            user_rid     <= '0;
            r_berr       <= 1'b0;
            rd_cnt       <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    user_arready <= 1'b0;
                    user_rvalid  <= 1'b1;
                    user_rid     <= user_arid;
                    user_rdata   <= r_fetch_dat;
                    user_rresp   <= r_fetch_resp;
                    user_rlast   <= (user_arlen == 8'd0);
                    r_berr       <= r_fetch_berr;
                    r_state      <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (user_rlast) begin
                        user_rvalid  <= 1'b0;
                        user_rlast   <= 1'b0;
                        user_arready <= 1'b1;
                        r_state      <= R_IDLE;
                        if (rd_cnt != 16'hFFFF)
                            rd_cnt <= rd_cnt + 16'd1;
                    end else begin
                        user_rdata <= r_fetch_dat;
                        user_rresp <= r_fetch_resp;
                        user_rlast <= r_last_nxt;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign status = {wr_cnt, rd_cnt};

    logic unused_ok;
    assign unused_ok = &{1'b0, user_wid, user_arsize, user_awsize, w_addr[2:0], r_fetch_addr[2:0],
                         w_unused_addr_nxt, w_unused_last_nxt, r_unused_addr, r_unused_last};

endmodule

// File: tb/tb_axi_mm_mem_responder.sv
// Bench for axi_mm_mem_responder: directed test-plan sequences, a write/read vector table,
// and randomized bursts checked against an array model of the memory.
module tb_axi_mm_mem_responder;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, MEM_DEPTH = 256;

    logic              clk_wr = 1'b0;
    logic              rst_wr = 1'b1;
    logic [ID_W-1:0]   user_arid, user_awid, user_wid, user_rid, user_bid;
    logic [2:0]        user_arsize, user_awsize;
    logic [7:0]        user_arlen, user_awlen;
    logic [1:0]        user_arburst, user_awburst, user_rresp, user_bresp;
    logic [ADDR_W-1:0] user_araddr, user_awaddr;
    logic              user_arvalid, user_arready, user_awvalid, user_awready;
    logic [DATA_W-1:0] user_wdata, user_rdata;
    logic [7:0]        user_wstrb;
    logic              user_wlast, user_wvalid, user_wready;
    logic              user_rlast, user_rvalid, user_rready;
    logic              user_bvalid, user_bready;
    logic [31:0]       status;

    always #5 clk_wr = ~clk_wr;

    axi_mm_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
        .user_arburst(user_arburst), .user_araddr(user_araddr),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
        .user_awburst(user_awburst), .user_awaddr(user_awaddr),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
        .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready), .status(status)
    );

    int tests = 0, fails = 0;
    int wr_done = 0, rd_done = 0;

    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] mem_m [MEM_DEPTH];
    logic [63:0] rd_dat [$];
    logic [1:0]  rd_rsp [$];
    logic        rd_lst [$];
    logic [3:0]  rd_id  [$];
    logic [1:0]  got_bresp;
    logic [3:0]  got_bid;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          nb;
        logic [1:0]  exp_bresp;
    } wcase_t;
    wcase_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: got timeout required DUT handshake", nm);
    endtask

    function automatic logic [63:0] init_val(input int i);
        return {32'hC0DE0000 + 32'(i), ~32'(i)};
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
        return (burst == 2'b00) ? a : a + 32'(8 * i);
    endfunction

    // Reference write: apply strobed beats to the model and return the expected bresp.
    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [7:0] len,
                                               input logic [1:0] burst, input int nb);
        logic [1:0] r = (burst == 2'b11) ? 2'd2 : 2'd0;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba = beat_addr(a, burst, i);
            if (ba >= 32'(MEM_DEPTH * 8)) r = 2'd3;
            else if (burst != 2'b11)
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) mem_m[ba[10:3]][8*b +: 8] = wd[i][8*b +: 8];
        end
        if (nb != int'(len) + 1 && r < 2'd2) r = 2'd2;
        return r;
    endfunction

    function automatic logic [65:0] model_beat(input logic [31:0] a, input logic [1:0] burst, input int i);
        logic [31:0] ba  = beat_addr(a, burst, i);
        logic        oor = (ba >= 32'(MEM_DEPTH * 8));
        logic [1:0]  r   = oor ? 2'd3 : (burst == 2'b11) ? 2'd2 : 2'd0;
        return {r, (oor || burst == 2'b11) ? 64'd0 : mem_m[ba[10:3]]};
    endfunction

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        @(negedge clk_wr);
        user_awid = id; user_awaddr = a; user_awlen = len; user_awburst = burst;
        user_awsize = 3'd3; user_awvalid = 1'b1;
        while (!user_awready && t < 100) begin @(negedge clk_wr); t++; end
        if (t >= 100) tmo("aw_accept");
        @(negedge clk_wr);
        user_awvalid = 1'b0;
    endtask

    task automatic send_w(input int nb);
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            user_wdata = wd[i]; user_wstrb = ws[i]; user_wlast = (i == nb - 1);
            user_wid = 4'hA; user_wvalid = 1'b1;
            while (!user_wready && t < 100) begin @(negedge clk_wr); t++; end
            if (t >= 100) tmo("w_accept");
            @(negedge clk_wr);
        end
        user_wvalid = 1'b0; user_wlast = 1'b0;
    endtask

    task automatic recv_b();
        int t = 0;
        user_bready = 1'b1;
        while (!user_bvalid && t < 100) begin @(negedge clk_wr); t++; end
        if (t >= 100) tmo("b_valid");
        got_bresp = user_bresp; got_bid = user_bid;
        @(negedge clk_wr);
        user_bready = 1'b0;
        wr_done++;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] burst);
        int t = 0;
        @(negedge clk_wr);
        user_arid = id; user_araddr = a; user_arlen = len; user_arburst = burst;
        user_arsize = 3'd3; user_arvalid = 1'b1;
        while (!user_arready && t < 100) begin @(negedge clk_wr); t++; end
        if (t >= 100) tmo("ar_accept");
        @(negedge clk_wr);
        user_arvalid = 1'b0;
    endtask

    // Collect R beats; optionally stall with rready low for stall_cyc cycles before beat stall_beat.
    task automatic recv_r(input int stall_beat, input int stall_cyc, input bit rnd);
        int  t = 0;
        bit  done = 1'b0, stalled = 1'b0;
        rd_dat.delete(); rd_rsp.delete(); rd_lst.delete(); rd_id.delete();
        while (!done && t < 2000) begin
            @(negedge clk_wr); t++;
            if (user_rvalid && rd_dat.size() == stall_beat && !stalled && stall_cyc > 0) begin
                logic [63:0] sd = user_rdata;
                logic [2:0]  sc = {user_rlast, user_rresp};
                stalled = 1'b1;
                user_rready = 1'b0;
                repeat (stall_cyc) begin
                    @(negedge clk_wr);
                    chk("r_stall_data", user_rdata, sd);
                    chk("r_stall_ctl", {user_rvalid, user_rlast, user_rresp}, {1'b1, sc});
                end
            end
            user_rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (user_rvalid && user_rready) begin
                rd_dat.push_back(user_rdata); rd_rsp.push_back(user_rresp);
                rd_lst.push_back(user_rlast); rd_id.push_back(user_rid);
                if (user_rlast) done = 1'b1;
            end
        end
        if (!done) tmo("r_last");
        @(negedge clk_wr);
        user_rready = 1'b0;
        rd_done++;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] burst, input int nb);
        logic [1:0] exp;
        send_aw(id, a, len, burst);
        send_w(nb);
        recv_b();
        exp = model_write(a, len, burst, nb);
        chk("bresp_model", got_bresp, exp);
        chk("bid", got_bid, id);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input bit rnd);
        send_ar(id, a, len, burst);
        recv_r(-1, 0, rnd);
        chk("r_beat_count", rd_dat.size(), int'(len) + 1);
        if (rd_id.size() > 0) chk("rid", rd_id[0], id);
        for (int i = 0; i < rd_dat.size() && i <= int'(len); i++) begin
            logic [65:0] m = model_beat(a, burst, i);
            chk("rdata_model", rd_dat[i], m[63:0]);
            chk("rresp_model", rd_rsp[i], m[65:64]);
            chk("rlast_pos", rd_lst[i], (i == int'(len)));
        end
    endtask

    initial begin
        user_arvalid = 0; user_awvalid = 0; user_wvalid = 0; user_rready = 0; user_bready = 0;
        user_arid = 0; user_awid = 0; user_wid = 0; user_arsize = 0; user_awsize = 0;
        user_arlen = 0; user_awlen = 0; user_arburst = 0; user_awburst = 0;
        user_araddr = 0; user_awaddr = 0; user_wdata = 0; user_wstrb = 0; user_wlast = 0;

        tbl[0] = '{32'h200,  8'd3, 2'b01, 4, 2'd0};
        tbl[1] = '{32'h208,  8'd2, 2'b00, 3, 2'd0};
        tbl[2] = '{32'h7F0,  8'd3, 2'b10, 4, 2'd3};
        tbl[3] = '{32'h100,  8'd3, 2'b01, 2, 2'd2};
        tbl[4] = '{32'h120,  8'd1, 2'b01, 3, 2'd2};
        tbl[5] = '{32'h7F8,  8'd1, 2'b01, 3, 2'd3};
        tbl[6] = '{32'h180,  8'd0, 2'b11, 1, 2'd2};
        tbl[7] = '{32'h1000, 8'd0, 2'b00, 1, 2'd3};
        tbl[8] = '{32'h1A0,  8'd0, 2'b01, 1, 2'd0};

        repeat (3) @(negedge clk_wr);
        chk("rst_ready", {user_arready, user_awready}, 2'b11);
        chk("rst_valids", {user_wready, user_rvalid, user_bvalid, user_rlast}, 4'b0);
        chk("rst_rdata", user_rdata, 64'd0);
        chk("rst_status", status, 32'd0);
        rst_wr = 1'b0;

        for (int i = 0; i < 256; i++) begin wd[i] = init_val(i); ws[i] = 8'hFF; end
        do_write(4'd1, 32'h0, 8'd255, 2'b01, 256);

        // INCR write then read back 0x11..0x44
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h11 * (i + 1); ws[i] = 8'hFF; end
        do_write(4'd5, 32'h40, 8'd3, 2'b01, 4);
        chk("incr_bresp", got_bresp, 2'd0);
        send_ar(4'd7, 32'h40, 8'd3, 2'b01);
        chk("ar_to_rvalid", user_rvalid, 1'b1);
        recv_r(-1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd_dat[i], 64'h11 * (i + 1));
            chk("incr_rlast_rresp", {rd_lst[i], rd_rsp[i]}, {(i == 3), 2'd0});
        end

        // FIXED write keeps the last beat
        wd[0] = 64'hA; wd[1] = 64'hB; wd[2] = 64'hC;
        do_write(4'd2, 32'h08, 8'd2, 2'b00, 3);
        send_ar(4'd2, 32'h08, 8'd0, 2'b00);
        recv_r(-1, 0, 1'b0);
        chk("fixed_rdata", rd_dat[0], 64'hC);
        chk("fixed_rlast", rd_lst[0], 1'b1);

        // Partial strobe
        wd[0] = 64'd0; ws[0] = 8'hFF;
        do_write(4'd3, 32'h100, 8'd0, 2'b01, 1);
        wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'h0F;
        do_write(4'd3, 32'h100, 8'd0, 2'b01, 1);
        send_ar(4'd3, 32'h100, 8'd0, 2'b01);
        recv_r(-1, 0, 1'b0);
        chk("strb_rdata", rd_dat[0], 64'h00000000_FFFFFFFF);

        // Read straddling the top of memory
        send_ar(4'd4, 32'h7F8, 8'd1, 2'b01);
        recv_r(-1, 0, 1'b0);
        chk("edge_b0", {rd_rsp[0], rd_dat[0]}, {2'd0, init_val(255)});
        chk("edge_b1", {rd_rsp[1], rd_dat[1]}, {2'd3, 64'd0});

        // rready low 5 cycles mid-burst
        send_ar(4'd6, 32'h40, 8'd3, 2'b01);
        recv_r(2, 5, 1'b0);
        chk("stall_beats", rd_dat.size(), 4);
        for (int i = 0; i < 4; i++) chk("stall_rdata", rd_dat[i], 64'h11 * (i + 1));

        // Simultaneous AR and AW
        @(negedge clk_wr);
        user_awid = 4'd8; user_awaddr = 32'h300; user_awlen = 8'd0; user_awburst = 2'b01; user_awvalid = 1'b1;
        user_arid = 4'd9; user_araddr = 32'h40;  user_arlen = 8'd0; user_arburst = 2'b01; user_arvalid = 1'b1;
        chk("sim_both_ready", {user_awready, user_arready}, 2'b11);
        @(negedge clk_wr);
        chk("sim_both_taken", {user_awready, user_arready, user_wready, user_rvalid}, 4'b0011);
        user_awvalid = 1'b0; user_arvalid = 1'b0;
        wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hFF;
        send_w(1);
        recv_b();
        chk("sim_bresp", got_bresp, model_write(32'h300, 8'd0, 2'b01, 1));
        recv_r(-1, 0, 1'b0);
        chk("sim_rdata", rd_dat[0], 64'h11);

        // Vector table: expected bresp constants plus model read-back
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < tbl[k].nb; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            do_write(4'(k), tbl[k].addr, tbl[k].len, tbl[k].burst, tbl[k].nb);
            chk("tbl_bresp", got_bresp, tbl[k].exp_bresp);
            do_read(4'(k + 1), tbl[k].addr, tbl[k].len, tbl[k].burst, 1'b0);
        end

        // Randomized bursts against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a = 32'($urandom_range(0, 'h10F) * 8);
            logic [7:0]  len = 8'($urandom_range(0, 7));
            int          r = $urandom_range(0, 9);
            logic [1:0]  burst = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            int          nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : int'(len) + 1;
            for (int i = 0; i < nb; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            do_write(4'($urandom), a, len, burst, nb);
            do_read(4'($urandom), a, len, burst, 1'b1);
        end

        @(negedge clk_wr);
        chk("status_cnt", status, {16'(wr_done), 16'(rd_done)});

        // Reset in the middle of a read burst
        send_ar(4'd9, 32'h0, 8'd7, 2'b01);
        chk("pre_rst_rvalid", user_rvalid, 1'b1);
        rst_wr = 1'b1;
        #1;
        chk("mid_rst_outputs", {user_rvalid, user_arready, user_awready, user_rlast, user_bvalid}, 5'b01100);
        chk("mid_rst_status", status, 32'd0);
        @(negedge clk_wr);
        rst_wr = 1'b0;
        wr_done = 0; rd_done = 0;
        do_read(4'd2, 32'h40, 8'd3, 2'b01, 1'b0);
        @(negedge clk_wr);
        chk("post_rst_status", status, {16'(wr_done), 16'(rd_done)});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
